repair_tx: RTL and testbench

- Initiator side of the MBTRAIN REPAIR sub-state.
- Drives the three sideband handshakes: INIT, APPLY_DEGRADE and END. Each is a request sent, then a response awaited from the remote partner.
- Reports the local lane-health result to the partner as a 3-bit degrade encoding.
- Shares the sideband transmit path with the REPAIR responder: it gives and observes valid through i_valid_rx / o_valid_tx. Acknowledges completion to mbtrain.

---
 rtl/repair_pkg.sv | 67 ++++++
 rtl/repair_tx_sb_valid_ctrl.sv | 60 ++++++
 rtl/repair_tx.sv | 174 +++++++++++++++++
 tb/tb_repair_tx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/repair_pkg.sv
// Shared definitions for the MBTRAIN REPAIR initiator and responder.
// Holds the sideband message codes exchanged during REPAIR, the 3-bit
// lane degrade encodings, the state encodings of both sides and small
// helpers that map lane-health results and send states onto codes.
package repair_pkg;

    // Decoded sideband message codes (0000 means "no message")
    localparam logic [3:0] MSG_NONE             = 4'b0000;
    localparam logic [3:0] MSG_INIT_REQ         = 4'b0001;
    localparam logic [3:0] MSG_INIT_RESP        = 4'b0010;
    localparam logic [3:0] MSG_APPLY_DEG_REQ    = 4'b0011;
    localparam logic [3:0] MSG_APPLY_DEG_RESP   = 4'b0100;
    localparam logic [3:0] MSG_END_REQ          = 4'b0101;
    localparam logic [3:0] MSG_END_RESP         = 4'b0110;

    // Degrade encodings reported with APPLY_DEGRADE_REQUEST
    localparam logic [2:0] ENC_NONE   = 3'b000;
    localparam logic [2:0] ENC_FIRST  = 3'b001;
    localparam logic [2:0] ENC_SECOND = 3'b010;
    localparam logic [2:0] ENC_BOTH   = 3'b011;

    // Initiator states
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_SEND_INIT,
        TX_SEND_DEGRADE,
        TX_SEND_END,
        TX_TEST_FINISH,
        TX_TIMEOUT
    } tx_state_e;

    // Responder states
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_WAIT_INIT,
        RX_WAIT_DEGRADE,
        RX_WAIT_END,
        RX_TEST_FINISH,
        RX_TIMEOUT
    } rx_state_e;

    // Map the two half-link health results onto the degrade encoding
    function automatic logic [2:0] lane_encoding(input logic first_ok,
                                                 input logic second_ok);
        logic [2:0] enc;
        case ({second_ok, first_ok})
            2'b11:   enc = ENC_BOTH;
            2'b01:   enc = ENC_FIRST;
            2'b10:   enc = ENC_SECOND;
            default: enc = ENC_NONE;
        endcase
        return enc;
    endfunction

    // Response code that completes the handshake of a given send state
    function automatic logic [3:0] response_for(input tx_state_e st);
        logic [3:0] code;
        case (st)
            TX_SEND_INIT:    code = MSG_INIT_RESP;
            TX_SEND_DEGRADE: code = MSG_APPLY_DEG_RESP;
            TX_SEND_END:     code = MSG_END_RESP;
            default:         code = MSG_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/repair_tx_sb_valid_ctrl.sv
// Sideband transmit-request control shared by the REPAIR initiator and
// responder. A pending request is armed on state entry; valid is raised
// once the other side does not own the transmit path, and both drop
// when the sideband reports the end of the message.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   clear_i            abort: drop pending and valid
//   set_i              arm a new request (state entry)
//   valid_rx_i         the other side currently owns the transmit path
//   busy_negedge_i     sideband finished sending the current message
//   pending_o          request armed but not yet completed
//   valid_o            transmit request towards the sideband
module sb_valid_ctrl (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic set_i,
    input  logic valid_rx_i,
    input  logic busy_negedge_i,
    output logic pending_o,
    output logic valid_o
);

    logic pending_q, pending_d;
    logic valid_q, valid_d;

    // Arming a request on entry outranks a stale busy negedge; the busy
    // negedge in turn outranks raising valid in the same cycle. Once
    // valid is high the other side's ownership is no longer consulted.
    always_comb begin
        pending_d = pending_q;
        valid_d   = valid_q;
        if (clear_i) begin
            pending_d = 1'b0;
            valid_d   = 1'b0;
        end else if (set_i) begin
            pending_d = 1'b1;
            valid_d   = 1'b0;
        end else if (busy_negedge_i) begin
            pending_d = 1'b0;
            valid_d   = 1'b0;
        end else if (pending_q && !valid_q && !valid_rx_i) begin
            valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            valid_q   <= valid_d;
        end
    end

    assign pending_o = pending_q;
    assign valid_o   = valid_q;

endmodule

// File: rtl/repair_tx.sv
// MBTRAIN REPAIR initiator. Runs the INIT, APPLY_DEGRADE and END sideband
// handshakes in order, reports the local lane-health degrade encoding to
// the partner and acknowledges completion (or a response timeout) to
// mbtrain.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   i_en                               REPAIR enable; low aborts to IDLE
//   i_local_first/second_8_lanes_ok    local lane-health results
//   i_sideband_message                 decoded received message
//   i_busy_negedge_detected            sideband finished current message
//   i_valid_rx                         responder owns the transmit path
//   o_sideband_message                 message to transmit
//   o_sideband_data_lanes_encoding     degrade encoding
//   o_valid_tx                         transmit request
//   o_test_ack, o_repair_fail          completion and result
//   o_timeout                          a response wait expired
module repair_tx
    import repair_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 8000,
    parameter int CNT_W          = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic       i_local_first_8_lanes_ok,
    input  logic       i_local_second_8_lanes_ok,
    input  logic [3:0] i_sideband_message,
    input  logic       i_busy_negedge_detected,
    input  logic       i_valid_rx,
    output logic [3:0] o_sideband_message,
    output logic [2:0] o_sideband_data_lanes_encoding,
    output logic       o_valid_tx,
    output logic       o_test_ack,
    output logic       o_repair_fail,
    output logic       o_timeout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    tx_state_e        state_q, state_d;
    logic [3:0]       msg_q, msg_d;
    logic [2:0]       enc_q, enc_d;
    logic             resp_seen_q, resp_seen_d;
    logic             ack_q, ack_d;
    logic             fail_q, fail_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             resp_hit;
    logic             vc_set, vc_clear;
    logic             pending, valid;

    sb_valid_ctrl u_valid_ctrl (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear_i        (vc_clear),
        .set_i          (vc_set),
        .valid_rx_i     (i_valid_rx),
        .busy_negedge_i (i_busy_negedge_detected),
        .pending_o      (pending),
        .valid_o        (valid)
    );

    // A handshake completes once our request has left the sideband and the
    // matching response has been seen, either earlier or in this cycle.
    // The timeout counter only runs after the request has been sent, and
    // a response arriving in the last counted cycle still wins.
    always_comb begin
        state_d     = state_q;
        msg_d       = msg_q;
        enc_d       = enc_q;
        resp_seen_d = resp_seen_q;
        ack_d       = ack_q;
        fail_d      = fail_q;
        timeout_d   = timeout_q;
        cnt_d       = cnt_q;
        vc_set      = 1'b0;
        vc_clear    = 1'b0;
        resp_hit    = 1'b0;

        if (!i_en) begin
            state_d     = TX_IDLE;
            msg_d       = MSG_NONE;
            resp_seen_d = 1'b0;
            ack_d       = 1'b0;
            fail_d      = 1'b0;
            timeout_d   = 1'b0;
            cnt_d       = '0;
            vc_clear    = 1'b1;
        end else begin
            case (state_q)
                TX_IDLE: begin
                    state_d = TX_SEND_INIT;
                    enc_d   = lane_encoding(i_local_first_8_lanes_ok,
                                            i_local_second_8_lanes_ok);
                    msg_d   = MSG_INIT_REQ;
                    cnt_d   = '0;
                    vc_set  = 1'b1;
                end
                TX_SEND_INIT, TX_SEND_DEGRADE, TX_SEND_END: begin
                    resp_hit = (i_sideband_message == response_for(state_q));
                    if (!pending && !valid && (resp_seen_q || resp_hit)) begin
                        resp_seen_d = 1'b0;
                        cnt_d       = '0;
                        case (state_q)
                            TX_SEND_INIT: begin
                                state_d = TX_SEND_DEGRADE;
                                msg_d   = MSG_APPLY_DEG_REQ;
                                vc_set  = 1'b1;
                            end
                            TX_SEND_DEGRADE: begin
                                state_d = TX_SEND_END;
                                msg_d   = MSG_END_REQ;
                                vc_set  = 1'b1;
                            end
                            default: begin
                                state_d = TX_TEST_FINISH;
                                msg_d   = MSG_NONE;
                                ack_d   = 1'b1;
                                fail_d  = (enc_q == ENC_NONE);
                            end
                        endcase
                    end else begin
                        resp_seen_d = resp_seen_q | resp_hit;
                        if (!pending) begin
                            if (cnt_q == CNT_LAST) begin
                                state_d     = TX_TIMEOUT;
                                msg_d       = MSG_NONE;
                                timeout_d   = 1'b1;
                                resp_seen_d = 1'b0;
                                cnt_d       = '0;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= TX_IDLE;
            msg_q       <= MSG_NONE;
            enc_q       <= ENC_NONE;
            resp_seen_q <= 1'b0;
            ack_q       <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            msg_q       <= msg_d;
            enc_q       <= enc_d;
            resp_seen_q <= resp_seen_d;
            ack_q       <= ack_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
            cnt_q       <= cnt_d;
        end
    end

    assign o_sideband_message             = msg_q;
    assign o_sideband_data_lanes_encoding = enc_q;
    assign o_valid_tx                     = valid;
    assign o_test_ack                     = ack_q;
    assign o_repair_fail                  = fail_q;
    assign o_timeout                      = timeout_q;

endmodule

// File: tb/tb_repair_tx.sv
// Testbench for repair_tx. The bench plays the remote partner and the
// sideband: it answers valid with a busy-negedge pulse and returns
// responses, while expectations (message order, encoding, valid latency
// under contention, completion and timeout distance) are derived from
// the handshake rules with plain arithmetic.
module tb_repair_tx;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_en;
    logic       i_local_first_8_lanes_ok;
    logic       i_local_second_8_lanes_ok;
    logic [3:0] i_sideband_message;
    logic       i_busy_negedge_detected;
    logic       i_valid_rx;
    logic [3:0] o_sideband_message;
    logic [2:0] o_sideband_data_lanes_encoding;
    logic       o_valid_tx;
    logic       o_test_ack;
    logic       o_repair_fail;
    logic       o_timeout;

    int checks = 0;
    int errors = 0;

    repair_tx #(.TIMEOUT_CYCLES(TO), .CNT_W(13)) dut (
        .clk                            (clk),
        .rst_n                          (rst_n),
        .i_en                           (i_en),
        .i_local_first_8_lanes_ok       (i_local_first_8_lanes_ok),
        .i_local_second_8_lanes_ok      (i_local_second_8_lanes_ok),
        .i_sideband_message             (i_sideband_message),
        .i_busy_negedge_detected        (i_busy_negedge_detected),
        .i_valid_rx                     (i_valid_rx),
        .o_sideband_message             (o_sideband_message),
        .o_sideband_data_lanes_encoding (o_sideband_data_lanes_encoding),
        .o_valid_tx                     (o_valid_tx),
        .o_test_ack                     (o_test_ack),
        .o_repair_fail                  (o_repair_fail),
        .o_timeout                      (o_timeout)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Hard stop in case something wedges the sequence
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=hang expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] msg, input logic busy,
                                 input logic vrx);
        i_sideband_message      = msg;
        i_busy_negedge_detected = busy;
        i_valid_rx              = vrx;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs,
                               input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Handshake h (0 INIT, 1 APPLY_DEGRADE, 2 END): request 2h+1, response 2h+2
    function automatic logic [3:0] reqCode(input int h);
        return 4'(2 * h + 1);
    endfunction

    function automatic logic [3:0] respCode(input int h);
        return 4'(2 * h + 2);
    endfunction

    // Entered on the cycle right after the send state was entered
    task automatic runHandshake(input int h, input int contention,
                                input int busyLen, input int respDelay,
                                input bit early, input bit giveResp);
        int edges;
        logic [3:0] wrong;
        wrong = (h == 0) ? 4'b0110 : 4'b0010;
        checkOutput("req_msg", 16'(o_sideband_message), 16'(reqCode(h)));
        checkOutput("valid_at_entry", 16'(o_valid_tx), 16'd0);
        edges = 0;
        while (o_valid_tx !== 1'b1 && edges < 20) begin
            applyStimulus(4'h0, 1'b0, edges < contention);
            tick();
            edges++;
        end
        checkOutput("valid_latency", 16'(edges), 16'(contention + 1));
        for (int i = 0; i < busyLen; i++) begin
            applyStimulus((early && i == 0) ? respCode(h) : 4'h0, 1'b0,
                          1'($urandom % 2));
            tick();
        end
        checkOutput("valid_held", 16'(o_valid_tx), 16'd1);
        checkOutput("msg_held", 16'(o_sideband_message), 16'(reqCode(h)));
        applyStimulus(4'h0, 1'b1, 1'b0);
        tick();
        applyStimulus(4'h0, 1'b0, 1'b0);
        checkOutput("valid_drop", 16'(o_valid_tx), 16'd0);
        if (early) begin
            checkOutput("early_hold", 16'(o_sideband_message), 16'(reqCode(h)));
            tick();
        end else begin
            for (int i = 0; i < respDelay; i++) begin
                applyStimulus((i == 0) ? wrong : 4'h0, 1'b0, 1'b0);
                tick();
            end
            applyStimulus(4'h0, 1'b0, 1'b0);
            if (respDelay > 0)
                checkOutput("ignore_wrong", 16'(o_sideband_message), 16'(reqCode(h)));
            if (giveResp) begin
                applyStimulus(respCode(h), 1'b0, 1'b0);
                tick();
                applyStimulus(4'h0, 1'b0, 1'b0);
            end
        end
    endtask

    task automatic runSequence(input bit ok1, input bit ok2, input int initCont,
                               input bit initEarly, input bit rnd);
        int e;
        int cont, busyLen, dly;
        bit early;
        e = int'(ok1) + 2 * int'(ok2);
        i_local_first_8_lanes_ok  = ok1;
        i_local_second_8_lanes_ok = ok2;
        i_en = 1'b1;
        tick();
        checkOutput("enc_capture", 16'(o_sideband_data_lanes_encoding), 16'(e));
        for (int h = 0; h < 3; h++) begin
            cont    = (h == 0) ? initCont : (rnd ? int'($urandom_range(0, 3)) : 0);
            busyLen = rnd ? int'($urandom_range(1, 4)) : 2;
            dly     = rnd ? int'($urandom_range(1, 5)) : 3;
            early   = (h == 0) ? initEarly : (rnd ? 1'($urandom % 2) : 1'b0);
            if (h == 1)
                checkOutput("enc_degrade", 16'(o_sideband_data_lanes_encoding), 16'(e));
            runHandshake(h, cont, busyLen, dly, early, 1'b1);
        end
        checkOutput("ack", 16'(o_test_ack), 16'd1);
        checkOutput("repair_fail", 16'(o_repair_fail), 16'(e == 0));
        checkOutput("finish_msg", 16'(o_sideband_message), 16'd0);
        checkOutput("finish_valid", 16'(o_valid_tx), 16'd0);
        checkOutput("finish_timeout", 16'(o_timeout), 16'd0);
        tick();
        tick();
        checkOutput("ack_held", 16'(o_test_ack), 16'd1);
        i_en = 1'b0;
        tick();
        checkOutput("abort_ack", 16'(o_test_ack), 16'd0);
        checkOutput("abort_fail", 16'(o_repair_fail), 16'd0);
        checkOutput("abort_msg", 16'(o_sideband_message), 16'd0);
        checkOutput("enc_retained", 16'(o_sideband_data_lanes_encoding), 16'(e));
    endtask

    initial begin
        int n;
        int e;
        rst_n = 1'b0;
        i_en  = 1'b0;
        i_local_first_8_lanes_ok  = 1'b0;
        i_local_second_8_lanes_ok = 1'b0;
        applyStimulus(4'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_msg", 16'(o_sideband_message), 16'd0);
        checkOutput("rst_enc", 16'(o_sideband_data_lanes_encoding), 16'd0);
        checkOutput("rst_valid", 16'(o_valid_tx), 16'd0);
        checkOutput("rst_ack", 16'(o_test_ack), 16'd0);
        checkOutput("rst_fail", 16'(o_repair_fail), 16'd0);
        checkOutput("rst_timeout", 16'(o_timeout), 16'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] happy path, both halves ok");
        runSequence(1'b1, 1'b1, 0, 1'b0, 1'b0);
        $display("[TB] second half only, then no usable half");
        runSequence(1'b0, 1'b1, 0, 1'b0, 1'b0);
        runSequence(1'b0, 1'b0, 0, 1'b0, 1'b0);
        $display("[TB] contention on INIT");
        runSequence(1'b1, 1'b0, 5, 1'b0, 1'b0);
        $display("[TB] early INIT response");
        runSequence(1'b0, 1'b1, 0, 1'b1, 1'b0);
        $display("[TB] randomized sequences");
        repeat (6)
            runSequence(1'($urandom % 2), 1'($urandom % 2),
                        int'($urandom_range(0, 5)), 1'($urandom % 2), 1'b1);

        $display("[TB] busy negedge together with valid set condition");
        i_en = 1'b1;
        tick();
        applyStimulus(4'h0, 1'b1, 1'b0);
        tick();
        applyStimulus(4'h0, 1'b0, 1'b0);
        checkOutput("busy_over_set", 16'(o_valid_tx), 16'd0);
        tick();
        checkOutput("busy_over_set_after", 16'(o_valid_tx), 16'd0);
        i_en = 1'b0;
        tick();

        $display("[TB] APPLY_DEGRADE response timeout");
        i_local_first_8_lanes_ok  = 1'b1;
        i_local_second_8_lanes_ok = 1'b1;
        i_en = 1'b1;
        tick();
        runHandshake(0, 0, 2, 2, 1'b0, 1'b1);
        runHandshake(1, 0, 2, 0, 1'b0, 1'b0);
        n = 0;
        while (o_timeout !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checkOutput("timeout_distance", 16'(n), 16'(TO));
        checkOutput("timeout_msg", 16'(o_sideband_message), 16'd0);
        checkOutput("timeout_ack", 16'(o_test_ack), 16'd0);
        tick();
        checkOutput("timeout_held", 16'(o_timeout), 16'd1);
        i_en = 1'b0;
        tick();
        checkOutput("post_timeout_timeout", 16'(o_timeout), 16'd0);
        checkOutput("post_timeout_msg", 16'(o_sideband_message), 16'd0);
        checkOutput("post_timeout_valid", 16'(o_valid_tx), 16'd0);
        checkOutput("post_timeout_ack", 16'(o_test_ack), 16'd0);
        checkOutput("post_timeout_fail", 16'(o_repair_fail), 16'd0);

        $display("[TB] abort during END handshake, then restart");
        i_en = 1'b1;
        tick();
        runHandshake(0, 0, 1, 1, 1'b0, 1'b1);
        runHandshake(1, 0, 1, 1, 1'b0, 1'b1);
        checkOutput("end_req", 16'(o_sideband_message), 16'(reqCode(2)));
        tick();
        checkOutput("end_valid", 16'(o_valid_tx), 16'd1);
        i_en = 1'b0;
        tick();
        checkOutput("abort_valid", 16'(o_valid_tx), 16'd0);
        checkOutput("abort_end_msg", 16'(o_sideband_message), 16'd0);
        i_local_first_8_lanes_ok  = 1'b1;
        i_local_second_8_lanes_ok = 1'b0;
        e = 1;
        i_en = 1'b1;
        tick();
        checkOutput("restart_msg", 16'(o_sideband_message), 16'(reqCode(0)));
        checkOutput("restart_enc", 16'(o_sideband_data_lanes_encoding), 16'(e));
        i_en = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
